// File: rtl/jtkicker_obj_romslot_if.sv
// ---------------------------------------------------------------------------
// jtkicker_obj_romslot_if
//   Bundles the two buses around the object ROM slot:
//     - client side : rom_cs / rom_addr request, rom_ok / rom_data response
//     - SDRAM side  : sdram_req / sdram_addr request, sdram_ack / sdram_rdy /
//                     sdram_din response
//   Modports:
//     slave  : the ROM slot itself (answers the client, drives the SDRAM)
//     master : the surroundings (object drawer plus SDRAM controller)
// ---------------------------------------------------------------------------
interface jtkicker_obj_romslot_if #(
  parameter int AW = 13
) ();

  // Client bus
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic          rom_ok;
  logic [31:0]   rom_data;

  // SDRAM bus
  logic          sdram_req;
  logic [21:0]   sdram_addr;
  logic          sdram_ack;
  logic          sdram_rdy;
  logic [31:0]   sdram_din;

  modport slave (
    input  rom_cs, rom_addr, sdram_ack, sdram_rdy, sdram_din,
    output rom_ok, rom_data, sdram_req, sdram_addr
  );

  modport master (
    output rom_cs, rom_addr, sdram_ack, sdram_rdy, sdram_din,
    input  rom_ok, rom_data, sdram_req, sdram_addr
  );

endinterface

// File: rtl/jtkicker_obj_romslot.sv
// ---------------------------------------------------------------------------
// jtkicker_obj_romslot
//   One-entry read cache between the object drawer and the SDRAM controller.
//   A hit (same word address as the cached tag, entry valid, FSM idle) answers
//   the client combinationally in the same cycle. A miss launches a single
//   SDRAM word read at OFFSET + rom_addr; the returned word is cached under
//   the address that was latched when the request was launched.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   downloading  ROM download in progress: invalidates the cache and blocks
//                new SDRAM requests
//   bus          jtkicker_obj_romslot_if.slave
//                  rom_cs, rom_addr   -> client read request
//                  rom_ok, rom_data   <- hit flag and cached word
//                  sdram_req/addr     <- level request, held until ack
//                  sdram_ack          -> request accepted (1-cycle pulse)
//                  sdram_rdy/din      -> read data valid (1-cycle pulse)
// ---------------------------------------------------------------------------
module jtkicker_obj_romslot #(
  parameter int          AW     = 13,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   downloading,
  jtkicker_obj_romslot_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;

  // Cache entry
  logic          valid;
  logic [AW-1:0] tag;
  logic [31:0]   data;

  // Address of the fetch in flight; becomes the tag once the data lands
  logic [AW-1:0] pend_tag;

  logic          sdram_req;
  logic [21:0]   sdram_addr;

  // FSM strobes
  logic          hit;
  logic          start;   // launch a new SDRAM read this edge
  logic          accept;  // SDRAM took the request this edge
  logic          fill;    // SDRAM data is written into the cache this edge

  // Hits are only served from IDLE so a stale entry can never answer while
  // a fetch is outstanding, even when the address matches the old tag.
  assign hit = bus.rom_cs & valid & (tag == bus.rom_addr) & (state == IDLE);

  // -------------------------------------------------------------------------
  // Next-state and strobe logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first; a branch that left
  // one unassigned would turn it into a latch.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    accept   = 1'b0;
    fill     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rom_cs && !hit && !downloading) begin
          start    = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        // A data strobe coinciding with the ack belongs to no request of
        // ours yet, so only the ack is honoured here.
        if (bus.sdram_ack) begin
          accept   = 1'b1;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (bus.sdram_rdy) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // -------------------------------------------------------------------------
  // SDRAM request register
  // -------------------------------------------------------------------------
  // The address is a full 22-bit sum so a region placed near the top of the
  // SDRAM wraps around to the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      pend_tag   <= '0;
    end else begin
      if (start) begin
        sdram_req  <= 1'b1;
        sdram_addr <= OFFSET + 22'(bus.rom_addr);
        pend_tag   <= bus.rom_addr;
      end else if (accept) begin
        sdram_req  <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Cache entry
  // -------------------------------------------------------------------------
  // A download rewrites the ROM underneath us, so it wins over a fill that
  // lands in the same cycle: the word is stored but never marked valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= 32'd0;
    end else begin
      if (fill) begin
        data <= bus.sdram_din;
        tag  <= pend_tag;
      end
      if (downloading) begin
        valid <= 1'b0;
      end else if (fill) begin
        valid <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.rom_ok     = hit;
  assign bus.rom_data   = data;
  assign bus.sdram_req  = sdram_req;
  assign bus.sdram_addr = sdram_addr;

endmodule
